// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the dual-issue fetch stage.
//               fetch_entry_t is the canonical {instr, pc} queue entry layout;
//               the top level builds a width-matched copy of it for its own
//               parameterisation and hands that to the queue as a type
//               parameter.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Instructions fetched per cycle (two ROM ports: pc and pc+1).
  localparam int FETCH_WIDTH = 2;

  localparam int FETCH_INSTR_WIDTH = 32;
  localparam int FETCH_ADDR_WIDTH  = 32;

  typedef struct packed {
    logic [FETCH_INSTR_WIDTH-1:0] instr;
    logic [FETCH_ADDR_WIDTH-1:0]  pc;
  } fetch_entry_t;

  // Decode may request at most FETCH_WIDTH entries; anything larger is
  // treated as FETCH_WIDTH.
  function automatic logic [1:0] limit_to_fetch_width(input logic [1:0] req);
    return (req > 2'(FETCH_WIDTH)) ? 2'(FETCH_WIDTH) : req;
  endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular instruction buffer. Accepts FETCH_WIDTH entries per
//               push, releases 0..2 entries per cycle, exposes the two oldest
//               entries and the current occupancy. Flush empties the buffer.
// Ports       : clk, rst_n          clock / synchronous active-low reset
//               flush               discard all entries (wins over push/pop)
//               push                write push_data_1 then push_data_2
//               pop_count           entries to release (caller pre-clamps)
//               head_1 / head_2     oldest / second-oldest entry (raw storage)
//               count               occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = fetch_entry_t,
  parameter int  CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  ENTRY_T        push_data_1,
  input  ENTRY_T        push_data_2,
  input  logic [1:0]    pop_count,
  output ENTRY_T        head_1,
  output ENTRY_T        head_2,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  ENTRY_T          mem_q [DEPTH];
  ENTRY_T          mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  // DEPTH is a power of two, so pointer overflow is the wrap-around.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop_count);
      count_d  = count_q - CW'(pop_count);
      // Writing into slots being popped this same cycle is safe: the heads
      // are read from the pre-edge storage.
      if (push) begin
        mem_d[wr_ptr_q]          = push_data_1;
        mem_d[wr_ptr_q + PW'(1)] = push_data_2;
        wr_ptr_d                 = wr_ptr_q + PW'(FETCH_WIDTH);
        count_d                  = count_d + CW'(FETCH_WIDTH);
      end
    end
  end

  // Storage needs no reset; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_1 = mem_q[rd_ptr_q];
  assign head_2 = mem_q[rd_ptr_q + PW'(1)];
  assign count  = count_q;

endmodule : fetch_queue
`default_nettype wire

// File: rtl/dual_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : dual_fetch_unit
// Description : Dual-issue fetch stage in front of a zero-latency dual-port
//               instruction ROM. Holds the PC, reads pc and pc+1 every cycle,
//               enqueues both words when room remains after this cycle's
//               dequeue, and shows the two oldest queue entries to decode.
//               A redirect flushes the queue and reloads the PC.
// Ports       : clk, rst_n                      clock / sync active-low reset
//               redirect_valid, redirect_addr   taken branch: flush + new PC
//               im_address_1/2                  ROM addresses pc / pc+1
//               im_read_data_1/2                ROM words (same cycle)
//               instr_valid_1, instr_1, pc_1    slot 1 (queue head)
//               instr_valid_2, instr_2, pc_2    slot 2 (head+1)
//               deq_count                       entries decode consumes (0..2)
//               queue_count                     current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module dual_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH_IM = 1,
  parameter int INSTR_WIDTH   = 1,
  parameter int QUEUE_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           redirect_valid,
  input  logic [ADDR_WIDTH_IM-1:0]       redirect_addr,
  output logic [ADDR_WIDTH_IM-1:0]       im_address_1,
  output logic [ADDR_WIDTH_IM-1:0]       im_address_2,
  input  logic [INSTR_WIDTH-1:0]         im_read_data_1,
  input  logic [INSTR_WIDTH-1:0]         im_read_data_2,
  output logic                           instr_valid_1,
  output logic [INSTR_WIDTH-1:0]         instr_1,
  output logic [ADDR_WIDTH_IM-1:0]       pc_1,
  output logic                           instr_valid_2,
  output logic [INSTR_WIDTH-1:0]         instr_2,
  output logic [ADDR_WIDTH_IM-1:0]       pc_2,
  input  logic [1:0]                     deq_count,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  // Same layout as fetch_entry_t, sized to this instance.
  typedef struct packed {
    logic [INSTR_WIDTH-1:0]   instr;
    logic [ADDR_WIDTH_IM-1:0] pc;
  } entry_t;

  logic [ADDR_WIDTH_IM-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH_IM-1:0] pc_plus1;
  logic [1:0]               deq_req;
  logic [1:0]               deq_eff;
  logic [1:0]               pop_count;
  logic [CW-1:0]            count;
  logic [CW-1:0]            post_deq;
  logic                     enq;
  entry_t                   push_1, push_2;
  entry_t                   head_1, head_2;

  assign pc_plus1 = pc_q + ADDR_WIDTH_IM'(1);

  always_comb begin
    deq_req = limit_to_fetch_width(deq_count);
    // Never release more than is held; when the request exceeds occupancy
    // the occupancy is below FETCH_WIDTH, so its low two bits are exact.
    deq_eff = deq_req;
    if (CW'(deq_req) > count) begin
      deq_eff = count[1:0];
    end
    post_deq  = count - CW'(deq_eff);
    // Room for a full pair after this cycle's dequeue; redirect discards the
    // ROM words and the dequeue request.
    enq       = !redirect_valid && (post_deq <= CW'(QUEUE_DEPTH - FETCH_WIDTH));
    pop_count = redirect_valid ? 2'd0 : deq_eff;

    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_addr;
    end else if (enq) begin
      pc_d = pc_q + ADDR_WIDTH_IM'(FETCH_WIDTH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign push_1 = '{instr: im_read_data_1, pc: pc_q};
  assign push_2 = '{instr: im_read_data_2, pc: pc_plus1};

  fetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .ENTRY_T (entry_t),
    .CW      (CW)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (redirect_valid),
    .push        (enq),
    .push_data_1 (push_1),
    .push_data_2 (push_2),
    .pop_count   (pop_count),
    .head_1      (head_1),
    .head_2      (head_2),
    .count       (count)
  );

  assign im_address_1  = pc_q;
  assign im_address_2  = pc_plus1;
  assign queue_count   = count;

  // Slots read as zero while empty so stale storage never leaks out.
  assign instr_valid_1 = (count >= CW'(1));
  assign instr_valid_2 = (count >= CW'(2));
  assign instr_1       = instr_valid_1 ? head_1.instr : '0;
  assign pc_1          = instr_valid_1 ? head_1.pc    : '0;
  assign instr_2       = instr_valid_2 ? head_2.instr : '0;
  assign pc_2          = instr_valid_2 ? head_2.pc    : '0;

  // Decode asking for more than is held is clamped, but flagged.
  a_deq_within_count : assert property (
    @(posedge clk) disable iff (!rst_n)
    !redirect_valid |-> (CW'(deq_count) <= queue_count)
  ) else $warning("deq_count %0d exceeds queue occupancy %0d; clamped",
                  deq_count, queue_count);

endmodule : dual_fetch_unit
`default_nettype wire

// File: tb/tb_dual_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_fetch_unit
// Description : Self-checking bench for dual_fetch_unit. A queue-based model
//               of the fetch stage predicts the visible state after every
//               edge; a monitor compares the DUT against those predictions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_fetch_unit;

  localparam int AW   = 4;
  localparam int IW   = 8;
  localparam int QD   = 4;
  localparam int CW   = 3;
  localparam int ROMN = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic [AW-1:0] im_address_1, im_address_2;
  logic [IW-1:0] im_read_data_1, im_read_data_2;
  logic          instr_valid_1, instr_valid_2;
  logic [IW-1:0] instr_1, instr_2;
  logic [AW-1:0] pc_1, pc_2;
  logic [1:0]    deq_count;
  logic [CW-1:0] queue_count;

  logic [IW-1:0] rom [ROMN];

  always #5 clk = ~clk;

  assign im_read_data_1 = rom[im_address_1];
  assign im_read_data_2 = rom[im_address_2];

  dual_fetch_unit #(
    .ADDR_WIDTH_IM (AW),
    .INSTR_WIDTH   (IW),
    .QUEUE_DEPTH   (QD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .im_address_1   (im_address_1),
    .im_address_2   (im_address_2),
    .im_read_data_1 (im_read_data_1),
    .im_read_data_2 (im_read_data_2),
    .instr_valid_1  (instr_valid_1),
    .instr_1        (instr_1),
    .pc_1           (pc_1),
    .instr_valid_2  (instr_valid_2),
    .instr_2        (instr_2),
    .pc_2           (pc_2),
    .deq_count      (deq_count),
    .queue_count    (queue_count)
  );

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } ent_t;

  typedef struct packed {
    logic          v1;
    logic [IW-1:0] i1;
    logic [AW-1:0] p1;
    logic          v2;
    logic [IW-1:0] i2;
    logic [AW-1:0] p2;
    logic [CW-1:0] cnt;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
  } snap_t;

  ent_t  mq[$];     // model instruction queue, oldest first
  int    mpc;       // model program counter
  snap_t exp_q[$];  // expected visible state after each edge
  snap_t s;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model over the coming edge,
  // and queue the state the DUT should show afterwards.
  task automatic step(input bit rn, input bit rv, input int ra, input int dq, input bit scramble);
    ent_t  e;
    snap_t x;
    int    take;
    @(negedge clk);
    if (scramble) begin
      for (int i = 0; i < ROMN; i++) rom[i] = IW'($urandom);
    end
    rst_n          = rn;
    redirect_valid = rv;
    redirect_addr  = AW'(ra);
    deq_count      = 2'(dq);
    if (!rn) begin
      mq.delete();
      mpc = 0;
    end else if (rv) begin
      mq.delete();
      mpc = ra % ROMN;
    end else begin
      take = (dq < mq.size()) ? dq : mq.size();
      for (int k = 0; k < take; k++) void'(mq.pop_front());
      if (mq.size() <= QD - 2) begin
        e.instr = rom[mpc];                e.pc = AW'(mpc);
        mq.push_back(e);
        e.instr = rom[(mpc + 1) % ROMN];   e.pc = AW'((mpc + 1) % ROMN);
        mq.push_back(e);
        mpc = (mpc + 2) % ROMN;
      end
    end
    x.v1  = (mq.size() >= 1);
    x.i1  = x.v1 ? mq[0].instr : '0;
    x.p1  = x.v1 ? mq[0].pc    : '0;
    x.v2  = (mq.size() >= 2);
    x.i2  = x.v2 ? mq[1].instr : '0;
    x.p2  = x.v2 ? mq[1].pc    : '0;
    x.cnt = CW'(mq.size());
    x.a1  = AW'(mpc);
    x.a2  = AW'((mpc + 1) % ROMN);
    exp_q.push_back(x);
  endtask

  // Monitor: after every edge, compare the DUT against the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        s = exp_q.pop_front();
        chk("instr_valid_1", 32'(instr_valid_1), 32'(s.v1));
        chk("instr_1",       32'(instr_1),       32'(s.i1));
        chk("pc_1",          32'(pc_1),          32'(s.p1));
        chk("instr_valid_2", 32'(instr_valid_2), 32'(s.v2));
        chk("instr_2",       32'(instr_2),       32'(s.i2));
        chk("pc_2",          32'(pc_2),          32'(s.p2));
        chk("queue_count",   32'(queue_count),   32'(s.cnt));
        chk("im_address_1",  32'(im_address_1),  32'(s.a1));
        chk("im_address_2",  32'(im_address_2),  32'(s.a2));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    deq_count      = 2'd0;
    for (int i = 0; i < ROMN; i++) rom[i] = IW'(i);
    mq.delete();
    mpc = 0;

    repeat (2) step(1'b0, 1'b0, 0, 0, 1'b0);

    // Fill with no dequeue: two enqueues, then hold at 4.
    repeat (3) step(1'b1, 1'b0, 0, 0, 1'b0);

    // Steady two-per-cycle consumption.
    repeat (6) step(1'b1, 1'b0, 0, 2, 1'b0);

    // Alternating single dequeue / stall.
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 0, (k % 2 == 0) ? 1 : 0, 1'b0);

    // Refill, then redirect to 9 while full and decode asks for two.
    repeat (2) step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 9, 2, 1'b0);
    // Empty queue with deq_count=2: clamped to zero, enqueue still happens.
    step(1'b1, 1'b0, 0, 2, 1'b0);
    repeat (2) step(1'b1, 1'b0, 0, 0, 1'b0);

    // Redirect to the last address: pc+1 wraps to 0.
    step(1'b1, 1'b1, 15, 0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 0, 1, 1'b0);

    // New ROM contents so instr and pc values no longer coincide.
    step(1'b1, 1'b1, 3, 0, 1'b1);
    repeat (4) step(1'b1, 1'b0, 0, 1, 1'b0);

    // Reset together with redirect: reset wins.
    step(1'b0, 1'b1, 7, 2, 1'b0);
    repeat (3) step(1'b1, 1'b0, 0, 0, 1'b0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 19) == 0),
           int'($urandom_range(0, ROMN - 1)),
           int'($urandom_range(0, 2)),
           ($urandom_range(0, 99) == 0));
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dual_fetch_unit
`default_nettype wire
